// File: rtl/snitch_icache_lookup_arbiter_if.sv
// Bus bundle between the fetch requesters, the shared lookup pipeline and
// the flush controller. The arbiter uses the master view; the surrounding
// environment (requesters, lookup, flush source) uses the slave view.
interface snitch_icache_lookup_arbiter_if #(
  parameter int NR_REQ     = 4,
  parameter int FETCH_AW   = 48,
  parameter int LINE_WIDTH = 128,
  parameter int WAY_ALIGN  = 2
);
  localparam int IDW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [NR_REQ*FETCH_AW-1:0] req_addr_i;
  logic [NR_REQ-1:0]          req_valid_i;
  logic [NR_REQ-1:0]          req_ready_o;
  logic [LINE_WIDTH-1:0]      rsp_data_o;
  logic                       rsp_hit_o;
  logic                       rsp_error_o;
  logic [WAY_ALIGN-1:0]       rsp_way_o;
  logic [NR_REQ-1:0]          rsp_valid_o;
  logic [NR_REQ-1:0]          rsp_ready_i;
  logic                       flush_valid_i;
  logic                       flush_ready_o;
  logic [FETCH_AW-1:0]        lk_addr_o;
  logic [IDW-1:0]             lk_id_o;
  logic                       lk_valid_o;
  logic                       lk_ready_i;
  logic [LINE_WIDTH-1:0]      lk_data_i;
  logic                       lk_hit_i;
  logic                       lk_error_i;
  logic [WAY_ALIGN-1:0]       lk_way_i;
  logic [IDW-1:0]             lk_id_i;
  logic                       lk_valid_i;
  logic                       lk_ready_o;
  logic                       lk_flush_valid_o;
  logic                       lk_flush_ready_i;

  modport master (
    input  req_addr_i, req_valid_i, rsp_ready_i, flush_valid_i, lk_ready_i,
           lk_data_i, lk_hit_i, lk_error_i, lk_way_i, lk_id_i, lk_valid_i,
           lk_flush_ready_i,
    output req_ready_o, rsp_data_o, rsp_hit_o, rsp_error_o, rsp_way_o,
           rsp_valid_o, flush_ready_o, lk_addr_o, lk_id_o, lk_valid_o,
           lk_ready_o, lk_flush_valid_o
  );

  modport slave (
    output req_addr_i, req_valid_i, rsp_ready_i, flush_valid_i, lk_ready_i,
           lk_data_i, lk_hit_i, lk_error_i, lk_way_i, lk_id_i, lk_valid_i,
           lk_flush_ready_i,
    input  req_ready_o, rsp_data_o, rsp_hit_o, rsp_error_o, rsp_way_o,
           rsp_valid_o, flush_ready_o, lk_addr_o, lk_id_o, lk_valid_o,
           lk_ready_o, lk_flush_valid_o
  );
endinterface

// File: rtl/snitch_icache_lookup_arbiter.sv
// Shares one serial icache lookup pipeline among NR_REQ fetch requesters.
// Round-robin grant with a lock that holds a stalled grant stable, requester
// index used as the lookup ID, responses routed back by ID, and a flush
// sequencer that drains in-flight lookups before handshaking the flush.
//
// state | meaning
// RUN   | normal arbitration
// DRAIN | no new grants, wait for lock release and zero in-flight lookups
// FLUSH | lookup flush request asserted, waiting for its ack
// ACK   | one-cycle flush ack to the requester of the flush
module snitch_icache_lookup_arbiter #(
  parameter int NR_REQ       = 4,
  parameter int FETCH_AW     = 48,
  parameter int LINE_WIDTH   = 128,
  parameter int WAY_ALIGN    = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input logic clk_i,
  input logic rst_i,
  snitch_icache_lookup_arbiter_if.master bus
);
  localparam int IDW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int IFW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, ACK} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, gnt_idx;
  logic           lock_q, lock_d, gnt_valid, req_hs, rsp_hs;
  logic [IFW-1:0] inflight_q, inflight_d;
  logic [FETCH_AW-1:0] gnt_addr;
  logic [NR_REQ-1:0]   req_ready, rsp_valid;
  logic           rsp_ready_sel, lk_flush_valid, flush_ready;

  function automatic logic [IDW-1:0] wrap_add(logic [IDW-1:0] a, int unsigned b);
    int unsigned s;
    s = int'(a) + b;
    if (s >= NR_REQ) s = s - NR_REQ;
    return IDW'(s);
  endfunction

  // Grant selection: a locked grant wins outright, otherwise the first valid
  // requester from rr_q upward (descending loop so the smallest offset wins).
  always_comb begin
    gnt_idx   = lock_idx_q;
    gnt_valid = lock_q;
    if (!lock_q) begin
      gnt_idx = '0;
      if (state_q == RUN && inflight_q < IFW'(MAX_INFLIGHT)) begin
        for (int k = NR_REQ - 1; k >= 0; k--) begin
          if (bus.req_valid_i[wrap_add(rr_q, k)]) begin
            gnt_valid = 1'b1;
            gnt_idx   = wrap_add(rr_q, k);
          end
        end
      end
    end
  end

  // Request mux and response demux, both purely combinational.
  always_comb begin
    gnt_addr      = '0;
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_ready_sel = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (gnt_idx == IDW'(i)) gnt_addr = bus.req_addr_i[i*FETCH_AW +: FETCH_AW];
      if (gnt_valid && gnt_idx == IDW'(i)) req_ready[i] = bus.lk_ready_i;
      if (bus.lk_id_i == IDW'(i)) begin
        rsp_valid[i]  = bus.lk_valid_i;
        rsp_ready_sel = bus.rsp_ready_i[i];
      end
    end
  end

  assign req_hs = gnt_valid && bus.lk_ready_i;
  assign rsp_hs = bus.lk_valid_i && rsp_ready_sel;

  // Next-state logic for round-robin pointer, grant lock, in-flight count and
  // flush FSM. DRAIN looks at next-cycle values so the lookup flush starts
  // right after the last response handshake.
  always_comb begin
    rr_d           = rr_q;
    lock_d         = lock_q;
    lock_idx_d     = lock_idx_q;
    inflight_d     = inflight_q;
    state_d        = state_q;
    lk_flush_valid = 1'b0;
    flush_ready    = 1'b0;
    if (req_hs) begin
      rr_d   = wrap_add(gnt_idx, 1);
      lock_d = 1'b0;
    end else if (gnt_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    if (req_hs && !rsp_hs)      inflight_d = inflight_q + 1'b1;
    else if (!req_hs && rsp_hs) inflight_d = inflight_q - 1'b1;
    case (state_q)
      RUN:   if (bus.flush_valid_i) state_d = DRAIN;
      DRAIN: if (!lock_d && inflight_d == '0) state_d = FLUSH;
      FLUSH: begin
        lk_flush_valid = 1'b1;
        if (bus.lk_flush_ready_i) state_d = ACK;
      end
      ACK: begin
        flush_ready = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      inflight_q <= inflight_d;
    end
  end

  // Protocol checks: in-flight counter bounds and flush request held.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(req_hs && !rsp_hs && inflight_q == IFW'(MAX_INFLIGHT)));
      assert (!(rsp_hs && !req_hs && inflight_q == '0));
      assert (!((state_q == DRAIN || state_q == FLUSH) && !bus.flush_valid_i));
    end
  end

  assign bus.lk_valid_o       = gnt_valid;
  assign bus.lk_id_o          = gnt_idx;
  assign bus.lk_addr_o        = gnt_addr;
  assign bus.req_ready_o      = req_ready;
  assign bus.rsp_valid_o      = rsp_valid;
  assign bus.lk_ready_o       = rsp_ready_sel;
  assign bus.rsp_data_o       = bus.lk_data_i;
  assign bus.rsp_hit_o        = bus.lk_hit_i;
  assign bus.rsp_error_o      = bus.lk_error_i;
  assign bus.rsp_way_o        = bus.lk_way_i;
  assign bus.lk_flush_valid_o = lk_flush_valid;
  assign bus.flush_ready_o    = flush_ready;
endmodule
